// File: rtl/cbm2_bus_pkg.sv
// cbm2_bus_pkg: shared state type, widths and parameter legality check for the CBM-II bus sequencer
package cbm2_bus_pkg;
    typedef enum logic {RUN, STALL} state_t;
    localparam int CNT_W = 6;
    localparam int STALL_W = 7;
    function automatic logic params_ok(input int half_clks, input int vid_slot, input int cpu_slot,
                                       input int cpu_len, input int ram_timeout);
        return half_clks >= 8 && half_clks <= 64 && vid_slot < half_clks - 1 && cpu_len >= 1 &&
               cpu_slot + cpu_len <= half_clks - 1 && ram_timeout >= 1 && ram_timeout < 2 ** STALL_W;
    endfunction
endpackage

// File: rtl/cbm2_ram_handshake.sv
// cbm2_ram_handshake: SDRAM request tracking, stall decision, stall timeout and sticky error flag
module cbm2_ram_handshake
    import cbm2_bus_pkg::*;
#(
    parameter int RAM_TIMEOUT = 8
) (
    input  logic clk_sys,
    input  logic reset,
    input  logic req_fire,
    input  logic ram_ack,
    input  logic at_half_end,
    input  logic in_stall,
    output logic stall,
    output logic resume,
    output logic ram_err
);
    logic pending, timeout;
    logic [STALL_W-1:0] stall_cnt;
    assign timeout = in_stall && stall_cnt == STALL_W'(RAM_TIMEOUT - 1);
    assign stall = at_half_end && pending && !ram_ack;
    assign resume = in_stall && (ram_ack || timeout);
    // An ack only counts once the request is registered; a timeout with a simultaneous ack is an ack
    always_ff @(posedge clk_sys) begin
        if (reset) begin
            pending <= 1'b0;
            stall_cnt <= '0;
            ram_err <= 1'b0;
        end else begin
            pending <= req_fire || (pending && !ram_ack && !timeout);
            stall_cnt <= (in_stall && !resume) ? stall_cnt + STALL_W'(1) : '0;
            if (timeout && !ram_ack) ram_err <= 1'b1;
        end
    end
endmodule

// File: rtl/cbm2_bus_sequencer.sv
// cbm2_bus_sequencer: 1 MHz two-phase bus cycle generator with SDRAM stall, pause and 6509/IPC slot arbitration
module cbm2_bus_sequencer
    import cbm2_bus_pkg::*;
#(
    parameter int HALF_CLKS = 16,
    parameter int VID_SLOT = 2,
    parameter int CPU_SLOT = 4,
    parameter int CPU_LEN = 4,
    parameter int RAM_TIMEOUT = 8
) (
    input  logic clk_sys,
    input  logic reset,
    input  logic pause,
    input  logic ram_cs,
    input  logic ram_ack,
    input  logic copro_req,
    output logic phase,
    output logic vidCycle,
    output logic cpuCycle,
    output logic ram_req,
    output logic cpu_ce,
    output logic copro_ce,
    output logic copro_gnt,
    output logic ram_err
);
    if (!params_ok(HALF_CLKS, VID_SLOT, CPU_SLOT, CPU_LEN, RAM_TIMEOUT)) begin : g_bad_params
        $error("cbm2_bus_sequencer: illegal parameter combination");
    end
    localparam logic [CNT_W-1:0] LAST = CNT_W'(HALF_CLKS - 1);
    localparam logic [CNT_W-1:0] VID = CNT_W'(VID_SLOT);
    localparam logic [CNT_W-1:0] CPU_FIRST = CNT_W'(CPU_SLOT);
    localparam logic [CNT_W-1:0] CPU_END = CNT_W'(CPU_SLOT + CPU_LEN);
    state_t state;
    logic [CNT_W-1:0] cnt;
    logic paused, cpu_sel, run, half_end, req_fire, stall, resume, wrap, boundary;
    assign run = state == RUN && !paused;
    assign half_end = run && cnt == LAST;
    assign vidCycle = run && cnt == VID;
    assign cpuCycle = run && phase && cnt >= CPU_FIRST && cnt < CPU_END;
    assign req_fire = ram_cs && (vidCycle || (cpuCycle && cnt == CPU_FIRST));
    assign ram_req = req_fire;
    // A wrap is either an unstalled half end or the clock a stall resolves; in phase 1 it completes a cycle
    assign wrap = (half_end && !stall) || (state == STALL && resume);
    assign boundary = wrap && phase;
    assign cpu_ce = boundary && !cpu_sel;
    assign copro_ce = boundary && cpu_sel;
    assign copro_gnt = cpu_sel;
    cbm2_ram_handshake #(.RAM_TIMEOUT(RAM_TIMEOUT)) u_handshake (
        .clk_sys(clk_sys),
        .reset(reset),
        .req_fire(req_fire),
        .ram_ack(ram_ack),
        .at_half_end(half_end),
        .in_stall(state == STALL),
        .stall(stall),
        .resume(resume),
        .ram_err(ram_err)
    );
    // Slot counter, phase, run/stall state; pause and slot ownership change only at completed cycles
    always_ff @(posedge clk_sys) begin
        if (reset) begin
            cnt <= '0;
            phase <= 1'b0;
            state <= RUN;
            cpu_sel <= 1'b0;
            paused <= 1'b0;
        end else if (paused) begin
            paused <= pause;
        end else if (wrap) begin
            cnt <= '0;
            phase <= ~phase;
            state <= RUN;
            if (boundary) begin
                cpu_sel <= copro_req;
                paused <= pause;
            end
        end else if (stall) begin
            state <= STALL;
        end else if (run) begin
            cnt <= cnt + CNT_W'(1);
        end
    end
endmodule

// File: doc/cbm2_bus_sequencer.md
Name: cbm2_bus_sequencer

Overview:
- Bus-cycle initiator for the CBM-II system bus; drives the address decoder and data mux block that responds to its strobes.
- Divides clk_sys into 1 MHz system cycles, each with two phase halves.
- Issues the video and CPU access strobes (vidCycle, cpuCycle, phase) and the CPU and co-processor clock enables.
- Runs the SDRAM request/acknowledge handshake and stretches the cycle when the SDRAM is late.
- Arbitrates CPU-slot ownership between the 6509 and the IPC co-processor at cycle boundaries.

Parameters:
- HALF_CLKS, 16: clk_sys clocks per phase half. Legal range 8..64.
- VID_SLOT, 2: counter value at which vidCycle pulses, in both halves. Must be < HALF_CLKS-1.
- CPU_SLOT, 4: first counter value of the CPU window, phase 1 only.
- CPU_LEN, 4: CPU window length in clocks. Requires CPU_SLOT+CPU_LEN <= HALF_CLKS-1.
- RAM_TIMEOUT, 8: maximum stall clocks waiting for ram_ack.

Ports:
- clk_sys in 1: system clock.
- reset in 1: synchronous, active-high reset.
- pause in 1: freeze the bus at the next cycle boundary.
- ram_cs in 1: cs_ram from the decoder, valid in the strobe clock.
- ram_ack in 1: SDRAM completion, one-clock pulse.
- copro_req in 1: co-processor requests the CPU slot.
- phase out 1: 0 = first half, 1 = second half.
- vidCycle out 1: video access strobe.
- cpuCycle out 1: CPU access window.
- ram_req out 1: one-clock SDRAM request pulse.
- cpu_ce out 1: 6509 clock enable.
- copro_ce out 1: co-processor clock enable.
- copro_gnt out 1: CPU slot currently owned by the co-processor.
- ram_err out 1: sticky SDRAM timeout flag.

Behaviour:
- Reset (synchronous, active-high): cnt=0, phase=0, state RUN, cpu_sel=0, paused=0. All outputs 0, including ram_err.
- Counter: cnt (6 bits) increments each clock in RUN when not paused.
  - Wraps HALF_CLKS-1 -> 0 and toggles phase on the wrap.
  - Cycle boundary = the clock with cnt==HALF_CLKS-1 and phase==1.
- States:
  - RUN: counting; strobes active.
  - STALL: cnt and phase frozen; vidCycle, cpuCycle, cpu_ce and copro_ce all 0.
- vidCycle: 1 for exactly one clock when state==RUN, !paused and cnt==VID_SLOT, in either phase.
- cpuCycle: 1 when state==RUN, !paused, phase==1 and CPU_SLOT <= cnt < CPU_SLOT+CPU_LEN. The window is contiguous.
- ram_req:
  - Pulses in the vidCycle clock if ram_cs==1 in that clock.
  - Pulses in the first cpuCycle clock if ram_cs==1 in that clock.
  - Each pulse sets pending.
  - ram_ack clears pending only if it arrives on a clock strictly after the req clock. An ack in the same clock as req, or while not pending, is ignored.
- Stall entry: at cnt==HALF_CLKS-1 of any half, if pending then next state is STALL and cnt does not wrap.
- In STALL:
  - A stall counter increments each clock.
  - On ram_ack: pending=0, return to RUN, resume with the wrap (cnt=0, phase toggled).
  - If the stall counter reaches RAM_TIMEOUT without ack: ram_err=1 (sticky until reset), pending=0, resume the same way.
  - ram_ack in the same clock as timeout counts as ack; ram_err stays unchanged.
- CPU enables: at the cycle boundary in RUN (not entering STALL), pulse cpu_ce if cpu_sel==0, else copro_ce.
  - If STALL was entered at that boundary, the enable pulses in the resume clock instead.
  - Exactly one enable pulse per completed system cycle.
- Co-processor arbitration: at each completed boundary, cpu_sel <= copro_req. copro_gnt = cpu_sel. Ownership never changes mid-cycle.
- Pause: pause is sampled at each completed boundary.
  - If 1: paused=1; cnt holds at 0, phase holds at 0; all strobes and enables 0.
  - While paused, pause is sampled every clock; the first clock after it deasserts resumes at cnt=0, phase=0.
  - ram_req is never issued while paused.
- Reset mid-stall or mid-pause: immediate return to the reset state; a pending request is discarded.

Decomposition:
- Shared package cbm2_bus_pkg:
  - State enum: RUN, STALL.
  - Localparams: CNT_W=6, STALL_W=7.
  - Parameter-legality checks, as elaboration-time assertions.
- One natural sub-module, cbm2_ram_handshake: pending flag, stall counter, timeout and ram_err. Its interface is req_fire, ram_ack, at_half_end, and outputs stall and resume.

Test Plan:
- Free run after reset with defaults, ram_cs=0 -> vidCycle at clocks 2 and 18; cpuCycle for clocks 20..23; cpu_ce at clock 31; period 32; ram_req never asserted.
- ram_cs=1 during cpuCycle, ram_ack 3 clocks later -> one ram_req at clock 20; no stall; cpu_ce at clock 31.
- ram_cs=1 during cpuCycle, ram_ack 14 clocks after req -> STALL for 3 clocks; cpu_ce delayed 3 clocks (period 35); ram_err=0.
- ram_cs=1, no ram_ack -> STALL for exactly 8 clocks, then ram_err=1, counting resumes; ram_err stays 1 until reset.
- copro_req=1 asserted mid-cycle -> copro_gnt rises only at the next boundary; that boundary still pulses cpu_ce; the following boundaries pulse copro_ce; dropping the request returns the slot to cpu_ce one boundary later.
- pause=1 asserted mid-cycle -> the current cycle completes with cpu_ce, then no strobes; after pause deasserts, vidCycle appears 3 clocks later (cnt 0 -> 2). Reset asserted during STALL -> all outputs 0 next clock.
